codec_reg_arbiter: RTL and testbench

Shares the single CODEC register-access port (rd/wr strobe, address, data, read-valid) between two requesters: the CODEC init sequencer (requester 0) and the host register bridge (requester 1). It grants one transaction at a time using round-robin arbitration. It issues a one-cycle rd or wr strobe to the I2C controller and waits for completion or timeout. It then returns read data and a done/error pulse to the granted requester. It sits between the requesters and the I2C controller inside the codec unit.

---
 rtl/codec_pkg.sv | 21 ++
 rtl/codec_reg_arbiter_if.sv | 48 ++++
 rtl/codec_rr_arbiter2.sv | 20 ++
 rtl/codec_reg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_codec_reg_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
// Shared definitions for the codec unit: arbiter state encoding, CODEC
// register map addresses and the register reset-default value.
package codec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [7:0] REG_ADC_L_VOL    = 8'h00;
  localparam logic [7:0] REG_ADC_R_VOL    = 8'h01;
  localparam logic [7:0] REG_DAC_L_VOL    = 8'h02;
  localparam logic [7:0] REG_DAC_R_VOL    = 8'h03;
  localparam logic [7:0] REG_ANALOG_PATH  = 8'h04;
  localparam logic [7:0] REG_DIGITAL_PATH = 8'h05;

  localparam logic [8:0] REG_RESET_DEFAULT = 9'h097;

endpackage

// File: rtl/codec_reg_arbiter_if.sv
// Bundle of the requester side and the I2C-controller side of the CODEC
// register-access port.
//
// Handshake: a requester raises req_rd_en[i] and/or req_wr_en[i] (write wins
// if both) with stable addr/wdata and holds it as a level until it sees
// req_done[i] for one cycle; it drops the request on the following edge.
// req_rdata/req_error are valid only in the req_done cycle. Toward the I2C
// controller, codec_rd_en/codec_wr_en are one-cycle strobes with
// codec_reg_addr/codec_data_out stable until completion; the controller
// answers with a one-cycle codec_data_in_valid (read) or codec_wr_done (write).
interface codec_reg_arbiter_if;

  logic [1:0] req_rd_en;
  logic [1:0] req_wr_en;
  logic [7:0] req0_addr;
  logic [7:0] req1_addr;
  logic [8:0] req0_wdata;
  logic [8:0] req1_wdata;
  logic [1:0] req_grant;
  logic [1:0] req_done;
  logic       req_error;
  logic [8:0] req_rdata;
  logic       busy;
  logic       codec_rd_en;
  logic       codec_wr_en;
  logic [7:0] codec_reg_addr;
  logic [8:0] codec_data_out;
  logic [8:0] codec_data_in;
  logic       codec_data_in_valid;
  logic       codec_wr_done;

  // Arbiter side
  modport slave (
    input  req_rd_en, req_wr_en, req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  codec_data_in, codec_data_in_valid, codec_wr_done,
    output req_grant, req_done, req_error, req_rdata, busy,
    output codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out
  );

  // Requesters plus I2C controller side
  modport master (
    output req_rd_en, req_wr_en, req0_addr, req1_addr, req0_wdata, req1_wdata,
    output codec_data_in, codec_data_in_valid, codec_wr_done,
    input  req_grant, req_done, req_error, req_rdata, busy,
    input  codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out
  );

endinterface

// File: rtl/codec_rr_arbiter2.sv
// Combinational two-way round-robin pick. A lone pending requester wins;
// on a tie the requester that was not granted last wins.
module codec_rr_arbiter2 (
  input  logic [1:0] i_pending,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot pick from the pending mask and the last-grant pointer
  always_comb begin
    o_grant = 2'b00;
    case (i_pending)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/codec_reg_arbiter.sv
// Shares the single CODEC register-access port between the init sequencer
// (requester 0) and the host register bridge (requester 1). One transaction
// at a time: grant, one-cycle strobe, wait for completion or timeout, then a
// one-cycle done pulse back to the owner. All outputs are registered.
module codec_reg_arbiter
  import codec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  codec_reg_arbiter_if.slave bus,
  output arb_state_t         dbg_state
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       r_state,  w_state;
  logic [1:0]       r_grant,  w_grant;
  logic [1:0]       r_done,   w_done;
  logic             r_error,  w_error;
  logic [8:0]       r_rdata,  w_rdata;
  logic             r_busy,   w_busy;
  logic             r_rd_en,  w_rd_en;
  logic             r_wr_en,  w_wr_en;
  logic [7:0]       r_addr,   w_addr;
  logic [8:0]       r_wdata,  w_wdata;
  logic             r_op_wr,  w_op_wr;
  logic [CNT_W-1:0] r_cnt,    w_cnt;
  logic             r_last,   w_last;

  logic [1:0]       w_pending;
  logic [1:0]       w_pick;
  logic             w_pick_idx;
  logic             w_pick_wr;
  logic [7:0]       w_pick_addr;
  logic [8:0]       w_pick_wdata;
  logic             w_complete;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_pending = bus.req_rd_en | bus.req_wr_en;

  codec_rr_arbiter2 u_rr (
    .i_pending    (w_pending),
    .i_last_grant (r_last),
    .o_grant      (w_pick)
  );

  // Winner's request fields; write takes precedence when both ops are set
  assign w_pick_idx   = w_pick[1];
  assign w_pick_wr    = bus.req_wr_en[w_pick_idx];
  assign w_pick_addr  = w_pick_idx ? bus.req1_addr  : bus.req0_addr;
  assign w_pick_wdata = w_pick_idx ? bus.req1_wdata : bus.req0_wdata;

  // Only the completion pulse matching the latched op counts
  assign w_complete = r_op_wr ? bus.codec_wr_done : bus.codec_data_in_valid;

  // Saturating WAIT-cycle counter
  assign w_cnt_inc = (r_cnt == CNT_LIMIT) ? r_cnt : r_cnt + 1'b1;

  // Next-state and next-output logic
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_done  = 2'b00;
    w_error = r_error;
    w_rdata = r_rdata;
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_op_wr = r_op_wr;
    w_cnt   = r_cnt;
    w_last  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick != 2'b00) begin
          w_state = ST_ISSUE;
          w_grant = w_pick;
          w_op_wr = w_pick_wr;
          w_addr  = w_pick_addr;
          w_wdata = w_pick_wdata;
          w_rd_en = ~w_pick_wr;
          w_wr_en = w_pick_wr;
        end
      end
      ST_ISSUE: begin
        w_state = ST_WAIT;
        w_cnt   = '0;
      end
      ST_WAIT: begin
        w_cnt = w_cnt_inc;
        if (w_complete) begin
          w_state = ST_DONE;
          w_done  = r_grant;
          w_error = 1'b0;
          w_rdata = r_op_wr ? 9'h000 : bus.codec_data_in;
        end else if (w_cnt_inc == CNT_LIMIT) begin
          w_state = ST_DONE;
          w_done  = r_grant;
          w_error = 1'b1;
          w_rdata = 9'h000;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_last  = r_grant[1];
        w_grant = 2'b00;
        w_addr  = 8'h00;
        w_wdata = 9'h000;
        w_op_wr = 1'b0;
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_done  <= 2'b00;
      r_error <= 1'b0;
      r_rdata <= 9'h000;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 9'h000;
      r_op_wr <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_done  <= w_done;
      r_error <= w_error;
      r_rdata <= w_rdata;
      r_busy  <= w_busy;
      r_rd_en <= w_rd_en;
      r_wr_en <= w_wr_en;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_op_wr <= w_op_wr;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
    end
  end

  assign bus.req_grant      = r_grant;
  assign bus.req_done       = r_done;
  assign bus.req_error      = r_error;
  assign bus.req_rdata      = r_rdata;
  assign bus.busy           = r_busy;
  assign bus.codec_rd_en    = r_rd_en;
  assign bus.codec_wr_en    = r_wr_en;
  assign bus.codec_reg_addr = r_addr;
  assign bus.codec_data_out = r_wdata;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Bench for codec_reg_arbiter: directed scenarios with hand-computed
// expectations, then random requests and random completion pulses, all
// checked every cycle against a transaction-window model.
`timescale 1ns/1ps
module tb_codec_reg_arbiter;
  import codec_pkg::*;

  localparam int T = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  arb_state_t dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  codec_reg_arbiter_if bus ();

  codec_reg_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model state ----------------
  // A transaction occupies cycles [m_start, m_done_c]: m_start is the strobe
  // cycle, m_done_c the done cycle (-1 until the outcome is known).
  bit         m_active = 1'b0;
  int         m_owner, m_start, m_done_c;
  bit         m_wr, m_err;
  bit         m_last = 1'b1;
  logic [7:0] m_addr;
  logic [8:0] m_wdata, m_rdata;

  // observations of the DUT used by the directed literal checks
  int         strobe_cnt = 0, strobe_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic       strobe_wr;
  logic [7:0] strobe_addr;
  logic [8:0] strobe_data, done_rdata;
  logic [1:0] done_val;
  logic       done_err;
  logic [1:0] done_q[$];
  int         done_cq[$];
  logic [1:0] exp_q[$];
  logic [1:0] s_done = 2'b00;
  logic       s_rd = 1'b0;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    logic [1:0] e_grant, e_done, pend;
    logic       e_rd, e_wr, e_busy, hit;
    logic [7:0] e_addr;
    logic [8:0] e_data;
    int         w;
    if (reset) begin
      m_active = 1'b0;
      m_last   = 1'b1;
    end
    e_grant = 2'b00; e_done = 2'b00; e_rd = 1'b0; e_wr = 1'b0;
    e_busy = 1'b0; e_addr = 8'h00; e_data = 9'h000;
    if (m_active) begin
      e_grant = (m_owner == 1) ? 2'b10 : 2'b01;
      e_busy  = 1'b1;
      e_addr  = m_addr;
      e_data  = m_wdata;
      e_rd    = (cyc == m_start) && !m_wr;
      e_wr    = (cyc == m_start) && m_wr;
      if (cyc == m_done_c) e_done = e_grant;
    end
    chk("grant",      32'(bus.req_grant),         32'(e_grant));
    chk("done",       32'(bus.req_done),          32'(e_done));
    chk("busy",       32'(bus.busy),              32'(e_busy));
    chk("rd_strobe",  32'(bus.codec_rd_en),       32'(e_rd));
    chk("wr_strobe",  32'(bus.codec_wr_en),       32'(e_wr));
    chk("reg_addr",   32'(bus.codec_reg_addr),    32'(e_addr));
    chk("data_out",   32'(bus.codec_data_out),    32'(e_data));
    chk("state_busy", 32'(dbg_state != ST_IDLE),  32'(e_busy));
    if (e_done != 2'b00) begin
      chk("rdata", 32'(bus.req_rdata), 32'(m_rdata));
      chk("error", 32'(bus.req_error), 32'(m_err));
    end

    if (bus.codec_rd_en || bus.codec_wr_en) begin
      strobe_cnt++;
      strobe_cyc  = cyc;
      strobe_wr   = bus.codec_wr_en;
      strobe_addr = bus.codec_reg_addr;
      strobe_data = bus.codec_data_out;
    end
    if (bus.req_done != 2'b00) begin
      done_cnt++;
      done_cyc   = cyc;
      done_val   = bus.req_done;
      done_rdata = bus.req_rdata;
      done_err   = bus.req_error;
      done_q.push_back(bus.req_done);
      done_cq.push_back(cyc);
    end
    s_done = bus.req_done;
    s_rd   = bus.codec_rd_en;

    if (!reset) begin
      if (m_active) begin
        if (m_done_c < 0 && cyc > m_start && cyc <= m_start + T) begin
          hit = m_wr ? bus.codec_wr_done : bus.codec_data_in_valid;
          if (hit) begin
            m_done_c = cyc + 1;
            m_err    = 1'b0;
            m_rdata  = m_wr ? 9'h000 : bus.codec_data_in;
          end else if (cyc == m_start + T) begin
            m_done_c = cyc + 1;
            m_err    = 1'b1;
            m_rdata  = 9'h000;
          end
        end else if (cyc == m_done_c) begin
          m_last   = (m_owner == 1);
          m_active = 1'b0;
        end
      end else begin
        pend = bus.req_rd_en | bus.req_wr_en;
        if (pend != 2'b00) begin
          if (pend == 2'b11) w = m_last ? 0 : 1;
          else               w = pend[0] ? 0 : 1;
          m_active = 1'b1;
          m_owner  = w;
          m_start  = cyc + 1;
          m_done_c = -1;
          m_wr     = bus.req_wr_en[w];
          m_addr   = (w == 1) ? bus.req1_addr  : bus.req0_addr;
          m_wdata  = (w == 1) ? bus.req1_wdata : bus.req0_wdata;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_rd_en = 2'b00; bus.req_wr_en = 2'b00;
    bus.req0_addr = 8'h00; bus.req1_addr = 8'h00;
    bus.req0_wdata = 9'h000; bus.req1_wdata = 9'h000;
    bus.codec_data_in = 9'h000; bus.codec_data_in_valid = 1'b0; bus.codec_wr_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n0, d0, k;
    logic [1:0] act;
    logic [1:0] op;
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    chk("rst_grant", 32'(bus.req_grant), 32'(2'b00));
    chk("rst_done",  32'(bus.req_done),  32'(2'b00));
    chk("rst_busy",  32'(bus.busy),      32'(1'b0));
    chk("rst_state", 32'(dbg_state),     32'(ST_IDLE));
    reset = 1'b0;
    repeat (2) tick();

    // single read, requester 0, data returned three cycles after the strobe
    n0 = strobe_cnt; d0 = done_cnt;
    bus.req_rd_en = 2'b01; bus.req0_addr = REG_ADC_L_VOL;
    tick();                                    // strobe cycle
    repeat (2) tick();
    tick(); bus.codec_data_in_valid = 1'b1; bus.codec_data_in = REG_RESET_DEFAULT;
    tick(); bus.codec_data_in_valid = 1'b0; bus.codec_data_in = 9'h000;
    tick(); bus.req_rd_en = 2'b00;
    chk("t1_strobes", 32'(strobe_cnt - n0),       32'd1);
    chk("t1_op",      32'(strobe_wr),             32'd0);
    chk("t1_addr",    32'(strobe_addr),           32'h00);
    chk("t1_latency", 32'(done_cyc - strobe_cyc), 32'd4);
    chk("t1_done",    32'(done_val),              32'(2'b01));
    chk("t1_rdata",   32'(done_rdata),            32'h097);
    chk("t1_error",   32'(done_err),              32'd0);
    chk("t1_count",   32'(done_cnt - d0),         32'd1);
    tick();

    // single write, requester 1, completion five cycles after the strobe
    n0 = strobe_cnt;
    bus.req_wr_en = 2'b10; bus.req1_addr = REG_ANALOG_PATH; bus.req1_wdata = 9'h012;
    tick();
    repeat (4) tick();
    tick(); bus.codec_wr_done = 1'b1;
    tick(); bus.codec_wr_done = 1'b0;
    tick(); bus.req_wr_en = 2'b00;
    chk("t2_strobes", 32'(strobe_cnt - n0),       32'd1);
    chk("t2_op",      32'(strobe_wr),             32'd1);
    chk("t2_addr",    32'(strobe_addr),           32'h04);
    chk("t2_wdata",   32'(strobe_data),           32'h012);
    chk("t2_latency", 32'(done_cyc - strobe_cyc), 32'd6);
    chk("t2_done",    32'(done_val),              32'(2'b10));
    chk("t2_error",   32'(done_err),              32'd0);
    tick();

    // both requesters reading continuously: alternate 0,1,0,1
    d0 = done_cnt; done_q.delete(); done_cq.delete();
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    bus.req0_addr = REG_DAC_L_VOL; bus.req1_addr = REG_DAC_R_VOL;
    bus.req_rd_en = 2'b11;
    k = 0;
    while ((done_cnt - d0) < 4 && k < 60) begin
      tick(); k++;
      bus.codec_data_in_valid = s_rd;
      bus.codec_data_in       = 9'($urandom);
      bus.req_rd_en           = ((done_cnt - d0) >= 4) ? 2'b00 : ~s_done;
    end
    tick(); bus.codec_data_in_valid = 1'b0; bus.req_rd_en = 2'b00;
    chk("t3_count", 32'(done_cnt - d0), 32'd4);
    if (done_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", 32'(done_q[i]), 32'(exp_q[i]));
      for (int i = 0; i < 3; i++) chk("t3_gap", 32'(done_cq[i+1] - done_cq[i]), 32'd4);
    end
    tick();

    // timeout with no completion, then a normal transaction
    bus.req_rd_en = 2'b01; bus.req0_addr = REG_ADC_R_VOL;
    tick();
    repeat (T + 1) tick();
    tick(); bus.req_rd_en = 2'b00;
    chk("t4_latency", 32'(done_cyc - strobe_cyc), 32'(T + 1));
    chk("t4_done",    32'(done_val),              32'(2'b01));
    chk("t4_error",   32'(done_err),              32'd1);
    chk("t4_rdata",   32'(done_rdata),            32'h000);
    bus.req_rd_en = 2'b10; bus.req1_addr = REG_DIGITAL_PATH;
    tick();
    tick(); bus.codec_data_in_valid = 1'b1; bus.codec_data_in = 9'h1a5;
    tick(); bus.codec_data_in_valid = 1'b0;
    tick(); bus.req_rd_en = 2'b00;
    chk("t4b_done",  32'(done_val),   32'(2'b10));
    chk("t4b_error", 32'(done_err),   32'd0);
    chk("t4b_rdata", 32'(done_rdata), 32'h1a5);
    tick();

    // spurious completion pulses in IDLE, ISSUE and during a pending read
    d0 = done_cnt;
    bus.codec_data_in_valid = 1'b1; bus.codec_wr_done = 1'b1;
    repeat (2) tick();
    chk("t5_idle_done", 32'(done_cnt - d0), 32'd0);
    bus.codec_wr_done = 1'b0;
    bus.req_rd_en = 2'b01; bus.req0_addr = REG_DIGITAL_PATH;
    tick();                                    // strobe cycle, valid still high
    tick(); bus.codec_data_in_valid = 1'b0; bus.codec_wr_done = 1'b1;
    tick();
    tick(); bus.codec_wr_done = 1'b0; bus.codec_data_in_valid = 1'b1; bus.codec_data_in = 9'h0ab;
    tick(); bus.codec_data_in_valid = 1'b0;
    tick(); bus.req_rd_en = 2'b00;
    chk("t5_count",   32'(done_cnt - d0),         32'd1);
    chk("t5_latency", 32'(done_cyc - strobe_cyc), 32'd4);
    chk("t5_rdata",   32'(done_rdata),            32'h0ab);
    tick();

    // reset during WAIT aborts silently; a fresh read then completes
    d0 = done_cnt;
    bus.req_rd_en = 2'b01; bus.req0_addr = REG_DAC_R_VOL;
    tick();
    repeat (2) tick();
    reset = 1'b1; #1;
    chk("t6_grant", 32'(bus.req_grant),      32'(2'b00));
    chk("t6_busy",  32'(bus.busy),           32'd0);
    chk("t6_addr",  32'(bus.codec_reg_addr), 32'h00);
    chk("t6_state", 32'(dbg_state),          32'(ST_IDLE));
    bus.req_rd_en = 2'b00;
    tick(); reset = 1'b0;
    tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    bus.req_rd_en = 2'b01;
    tick();
    tick(); bus.codec_data_in_valid = 1'b1; bus.codec_data_in = 9'h155;
    tick(); bus.codec_data_in_valid = 1'b0;
    tick(); bus.req_rd_en = 2'b00;
    chk("t6_done",  32'(done_val),   32'(2'b01));
    chk("t6_rdata", 32'(done_rdata), 32'h155);
    chk("t6_error", 32'(done_err),   32'd0);
    tick();

    // random requests and random completion pulses
    d0 = done_cnt; act = 2'b00;
    for (int n = 0; n < 2000; n++) begin
      tick();
      bus.codec_data_in_valid = ($urandom_range(0, 5) == 0);
      bus.codec_wr_done       = ($urandom_range(0, 5) == 0);
      bus.codec_data_in       = 9'($urandom);
      for (int r = 0; r < 2; r++) begin
        if (act[r]) begin
          if (s_done[r]) begin
            act[r] = 1'b0;
            bus.req_rd_en[r] = 1'b0;
            bus.req_wr_en[r] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          act[r] = 1'b1;
          op = 2'($urandom_range(1, 3));
          bus.req_rd_en[r] = op[0];
          bus.req_wr_en[r] = op[1];
          if (r == 0) begin
            bus.req0_addr = 8'($urandom); bus.req0_wdata = 9'($urandom);
          end else begin
            bus.req1_addr = 8'($urandom); bus.req1_wdata = 9'($urandom);
          end
        end
      end
    end
    k = 0;
    while (act != 2'b00 && k < 60) begin
      tick(); k++;
      bus.codec_data_in_valid = 1'b0; bus.codec_wr_done = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (act[r] && s_done[r]) begin
          act[r] = 1'b0;
          bus.req_rd_en[r] = 1'b0;
          bus.req_wr_en[r] = 1'b0;
        end
      end
    end
    chk("rand_drained",  32'(act),                    32'(2'b00));
    chk("rand_activity", 32'((done_cnt - d0) > 100), 32'd1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
